ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- Decode/issue stage directly upstream of the execute ALU.
- Accepts one RV32I instruction per handshake and decodes it to the 4-bit ALU opcode.
- Selects and forwards operands A/B, and holds them in an output register that drives the ALU inputs.
- Provides valid/ready flow control, pipeline flush, and illegal-instruction flagging.

Parameters:
- XLEN, 32, datapath width of operands and PC; only 32 supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read, rs1 = instr[19:15]
- rs2_data  in  32  register-file read, rs2 = instr[24:20]
- exmem_we  in  1  EX/MEM stage writes a register
- exmem_rd  in  5  EX/MEM destination
- exmem_data  in  32  EX/MEM result
- memwb_we  in  1  MEM/WB stage writes a register
- memwb_rd  in  5  MEM/WB destination
- memwb_data  in  32  MEM/WB result
- flush  in  1  kill held/incoming instruction
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  execute stage consumes
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU opcode
- out_rd  out  5  destination register
- out_we  out  1  result writes register file
- out_pc  out  32  PC of held instruction
- out_illegal  out  1  held instruction undecodable

Behaviour:
- Reset (async, immediate): all outputs 0, including out_valid. in_ready = 1 after reset.
- in_ready = ~out_valid | out_ready (combinational). Accept = in_valid & in_ready.
- Edge priority: flush > accept > consume.
  - flush: out_valid <= 0; the incoming instruction is dropped even if accepted.
  - Accept: register all outputs, out_valid <= 1. Latency: instruction accepted at edge N appears on outputs after edge N.
  - out_valid & out_ready & ~in_valid: out_valid <= 0.
  - Otherwise hold; outputs are stable while out_valid & ~out_ready.
- ALU opcode encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, NOT A. NOT is never issued.
- OP (0110011): A = rs1, B = rs2; out_we = 1.
  - funct3 000: funct7 0000000 ADD, 0100000 SUB.
  - funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - funct3 101: funct7 0000000 SRL, 0100000 SRA.
  - Any other funct7 is illegal.
- OP-IMM (0010011): A = rs1, B = sign-extended I-immediate; same funct3 mapping; 000 always ADD; out_we = 1.
  - Shifts: B = {27'b0, instr[24:20]}.
  - funct3 001 requires instr[31:25] = 0. funct3 101 requires instr[31:25] = 0000000 (SRL) or 0100000 (SRA). Otherwise illegal.
- LUI: A = 0, B = {instr[31:12], 12'b0}, ADD, out_we = 1.
- AUIPC: A = pc, B = U-immediate, ADD, out_we = 1.
- LOAD: A = rs1, B = I-immediate, ADD, out_we = 1.
- STORE: A = rs1, B = S-immediate, ADD, out_we = 0.
- BRANCH: A = rs1, B = rs2, out_we = 0.
  - BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU.
  - funct3 010/011 illegal.
- Illegal (any other opcode or a bad field): out_illegal = 1, alu_op = 0, alu_a = alu_b = 0, out_we = 0. out_valid still asserted so the exception propagates.
- out_rd = instr[11:7] for writing classes, else 0. out_we forced to 0 when rd = x0.
- Forwarding per source register r, applied only where the operand comes from a register:
  - r = 0 → 0.
  - else exmem_we & exmem_rd == r → exmem_data.
  - else memwb_we & memwb_rd == r → memwb_data.
  - else register-file data.
  - Sampled in the accept cycle only; no re-forwarding while holding.
- out_pc = pc of the accepted instruction.
- Reset mid-stall clears the held instruction; nothing is replayed.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1_data = 5, rs2_data = 7, out_ready = 1 → next cycle out_valid = 1, alu_op = 0, alu_a = 5, alu_b = 7, out_rd = 3, out_we = 1.
- SRAI x5,x6,4 (0x40435293) → alu_op = 7, alu_b = 4; ADDI x1,x0,-1 (0xFFF00093) → alu_a = 0, alu_b = 0xFFFFFFFF, alu_op = 0.
- Forwarding: SUB x4,x1,x1 with exmem_rd = 1 / data 9 and memwb_rd = 1 / data 3, both we = 1 → alu_a = alu_b = 9, alu_op = 1. With rs = x0 and exmem_rd = 0 → operand 0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0, outputs stable; release → held instruction consumed and the next accepted in the same edge.
- flush asserted together with accept of BLTU → out_valid = 0 next cycle. Opcode 0x7F → out_illegal = 1, alu_op = 0, out_we = 0.
- rst pulsed asynchronously mid-hold → out_valid and all outputs 0 immediately, in_ready = 1.

Source files
------------

// File: rtl/ex_issue_stage_if.sv
// Issue-stage bundle: upstream instruction/operand handshake, EX/MEM and MEM/WB forwarding taps,
// and the registered ALU-facing outputs. "slave" is the issue stage, "master" its environment.
interface ex_issue_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            exmem_we;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_data;
  logic            memwb_we;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [4:0]      out_rd;
  logic            out_we;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data,
    input  exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
    input  flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_we, out_pc, out_illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data,
    output exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
    output flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_we, out_pc, out_illegal
  );
endinterface

// File: rtl/ex_issue_stage.sv
// RV32I decode/issue stage: decodes to a 4-bit ALU opcode, selects and forwards operands, and
// holds them in a valid/ready output register feeding the execute ALU.
module ex_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  ex_issue_stage_if.slave bus
);

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] F7Zero    = 7'b0000000;
  localparam logic [6:0] F7Alt     = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign shamt  = {27'b0, bus.instr[24:20]};

  // Youngest producer wins; x0 always reads as zero regardless of any pending write to it.
  always_comb begin
    rs1_fwd = bus.rs1_data;
    if (rs1 == 5'd0)                                rs1_fwd = '0;
    else if (bus.exmem_we && bus.exmem_rd == rs1)   rs1_fwd = bus.exmem_data;
    else if (bus.memwb_we && bus.memwb_rd == rs1)   rs1_fwd = bus.memwb_data;

    rs2_fwd = bus.rs2_data;
    if (rs2 == 5'd0)                                rs2_fwd = '0;
    else if (bus.exmem_we && bus.exmem_rd == rs2)   rs2_fwd = bus.exmem_data;
    else if (bus.memwb_we && bus.memwb_rd == rs2)   rs2_fwd = bus.memwb_data;
  end

  alu_op_e         f3_op;
  alu_op_e         alu_op_d, alu_op_q;
  logic [XLEN-1:0] alu_a_d, alu_a_q, alu_b_d, alu_b_q, out_pc_q;
  logic [4:0]      out_rd_d, out_rd_q;
  logic            out_we_d, out_we_q, illegal_d, illegal_q, valid_q;
  logic            writes_rd;

  // Shared OP / OP-IMM mapping for the funct3 values that need no funct7 qualifier.
  always_comb begin
    f3_op = AluAdd;
    unique case (funct3)
      3'b001:  f3_op = AluSll;
      3'b010:  f3_op = AluSlt;
      3'b011:  f3_op = AluSltu;
      3'b100:  f3_op = AluXor;
      3'b110:  f3_op = AluOr;
      3'b111:  f3_op = AluAnd;
      default: f3_op = AluAdd;
    endcase
  end

  always_comb begin
    alu_op_d  = AluAdd;
    alu_a_d   = '0;
    alu_b_d   = '0;
    illegal_d = 1'b0;
    writes_rd = 1'b0;
    unique case (opcode)
      OpcOp: begin
        alu_a_d   = rs1_fwd;
        alu_b_d   = rs2_fwd;
        writes_rd = 1'b1;
        if (funct3 == 3'b000 || funct3 == 3'b101) begin
          if (funct7 == F7Zero)     alu_op_d = (funct3 == 3'b000) ? AluAdd : AluSrl;
          else if (funct7 == F7Alt) alu_op_d = (funct3 == 3'b000) ? AluSub : AluSra;
          else                      illegal_d = 1'b1;
        end else begin
          alu_op_d  = f3_op;
          illegal_d = (funct7 != F7Zero);
        end
      end
      OpcOpImm: begin
        alu_a_d   = rs1_fwd;
        alu_b_d   = imm_i;
        writes_rd = 1'b1;
        alu_op_d  = f3_op;
        if (funct3 == 3'b001) begin
          alu_b_d   = shamt;
          illegal_d = (funct7 != F7Zero);
        end else if (funct3 == 3'b101) begin
          alu_b_d = shamt;
          if (funct7 == F7Zero)     alu_op_d = AluSrl;
          else if (funct7 == F7Alt) alu_op_d = AluSra;
          else                      illegal_d = 1'b1;
        end
      end
      OpcLui: begin
        alu_b_d   = imm_u;
        writes_rd = 1'b1;
      end
      OpcAuipc: begin
        alu_a_d   = bus.pc;
        alu_b_d   = imm_u;
        writes_rd = 1'b1;
      end
      OpcLoad: begin
        alu_a_d   = rs1_fwd;
        alu_b_d   = imm_i;
        writes_rd = 1'b1;
      end
      OpcStore: begin
        alu_a_d = rs1_fwd;
        alu_b_d = imm_s;
      end
      OpcBranch: begin
        alu_a_d = rs1_fwd;
        alu_b_d = rs2_fwd;
        unique case (funct3)
          3'b000, 3'b001: alu_op_d  = AluSub;
          3'b100, 3'b101: alu_op_d  = AluSlt;
          3'b110, 3'b111: alu_op_d  = AluSltu;
          default:        illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase

    out_rd_d = writes_rd ? rd : 5'd0;
    out_we_d = writes_rd && (rd != 5'd0);

    // Illegal instructions still issue so the exception travels down the pipe, but inertly.
    if (illegal_d) begin
      alu_op_d = AluAdd;
      alu_a_d  = '0;
      alu_b_d  = '0;
      out_rd_d = 5'd0;
      out_we_d = 1'b0;
    end
  end

  logic accept;
  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_op_q  <= AluAdd;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      out_rd_q  <= 5'd0;
      out_we_q  <= 1'b0;
      out_pc_q  <= '0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      out_rd_q  <= out_rd_d;
      out_we_q  <= out_we_d;
      out_pc_q  <= bus.pc;
      illegal_q <= illegal_d;
    end else if (valid_q && bus.out_ready && !bus.in_valid) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_we      = out_we_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: expected issue records are queued at acceptance and
// compared field by field whenever the stage hands a record to execute.
module tb_ex_issue_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_issue_stage_if bus ();

  ex_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic        f_ewe = 1'b0, f_mwe = 1'b0;
  logic [4:0]  f_erd = 5'd0, f_mrd = 5'd0;
  logic [31:0] f_edata = '0, f_mdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic we,
                              input logic [31:0] pc, input logic ill);
    exp_t e;
    e.name = name; e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [31:0] edata,
                         input logic mwe, input logic [4:0] mrd, input logic [31:0] mdata);
    f_ewe = ewe; f_erd = erd; f_edata = edata;
    f_mwe = mwe; f_mrd = mrd; f_mdata = mdata;
  endtask

  // Drives one instruction for the next edge; queues its expectation once acceptance is certain.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic fl, input exp_t e);
    int waited = 0;
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.instr      = instr;
    bus.pc         = pc;
    bus.rs1_data   = rs1;
    bus.rs2_data   = rs2;
    bus.flush      = fl;
    bus.exmem_we   = f_ewe; bus.exmem_rd = f_erd; bus.exmem_data = f_edata;
    bus.memwb_we   = f_mwe; bus.memwb_rd = f_mrd; bus.memwb_data = f_mdata;
    #1;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!bus.in_ready) check({e.name, ".accept_timeout"}, 32'(bus.in_ready), 32'd1);
    else if (!fl)      sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, ".alu_op"},  32'(bus.alu_op),      32'(e.op));
        check({e.name, ".alu_a"},   bus.alu_a,            e.a);
        check({e.name, ".alu_b"},   bus.alu_b,            e.b);
        check({e.name, ".out_rd"},  32'(bus.out_rd),      32'(e.rd));
        check({e.name, ".out_we"},  32'(bus.out_we),      32'(e.we));
        check({e.name, ".out_pc"},  bus.out_pc,           e.pc);
        check({e.name, ".illegal"}, 32'(bus.out_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t ea, eb;
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.exmem_we = 1'b0; bus.exmem_rd = '0; bus.exmem_data = '0;
    bus.memwb_we = 1'b0; bus.memwb_rd = '0; bus.memwb_data = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;

    #1 rst = 1'b1;
    #10;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready",  32'(bus.in_ready),  32'd1);
    check("rst.alu_a",     bus.alu_a,          32'd0);
    check("rst.out_pc",    bus.out_pc,         32'd0);
    @(negedge clk) rst = 1'b0;

    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    send(32'h002081B3, 32'h1000, 32'd5, 32'd7, 1'b0, mk("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'h1000, 1'b0));
    send(32'h40435293, 32'h1004, 32'h80000000, 32'd0, 1'b0,
         mk("srai", 4'd7, 32'h80000000, 32'd4, 5'd5, 1'b1, 32'h1004, 1'b0));
    send(32'hFFF00093, 32'h1008, 32'd123, 32'd0, 1'b0,
         mk("addi", 4'd0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 32'h1008, 1'b0));
    set_fwd(1'b1, 5'd1, 32'd9, 1'b1, 5'd1, 32'd3);
    send(32'h40108233, 32'h100C, 32'd100, 32'd100, 1'b0,
         mk("sub_fwd_ex", 4'd1, 32'd9, 32'd9, 5'd4, 1'b1, 32'h100C, 1'b0));
    set_fwd(1'b0, 5'd1, 32'd9, 1'b1, 5'd1, 32'd3);
    send(32'h40108233, 32'h1010, 32'd100, 32'd100, 1'b0,
         mk("sub_fwd_wb", 4'd1, 32'd3, 32'd3, 5'd4, 1'b1, 32'h1010, 1'b0));
    set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    send(32'h000003B3, 32'h1014, 32'd11, 32'd22, 1'b0,
         mk("add_x0_src", 4'd0, 32'd0, 32'd0, 5'd7, 1'b1, 32'h1014, 1'b0));
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    send(32'h12345137, 32'h1018, 32'hAA, 32'd0, 1'b0,
         mk("lui", 4'd0, 32'd0, 32'h12345000, 5'd2, 1'b1, 32'h1018, 1'b0));
    send(32'h00001197, 32'h0100, 32'd0, 32'd0, 1'b0,
         mk("auipc", 4'd0, 32'h100, 32'h1000, 5'd3, 1'b1, 32'h0100, 1'b0));
    send(32'h0020A423, 32'h0104, 32'h2000, 32'h77, 1'b0,
         mk("sw", 4'd0, 32'h2000, 32'd8, 5'd0, 1'b0, 32'h0104, 1'b0));
    send(32'h0020D063, 32'h0108, 32'd3, 32'd4, 1'b0,
         mk("bge", 4'd8, 32'd3, 32'd4, 5'd0, 1'b0, 32'h0108, 1'b0));
    send(32'h00409293, 32'h010C, 32'h11, 32'd0, 1'b0,
         mk("slli", 4'd5, 32'h11, 32'd4, 5'd5, 1'b1, 32'h010C, 1'b0));
    send(32'h00208033, 32'h0110, 32'd1, 32'd2, 1'b0,
         mk("add_rd_x0", 4'd0, 32'd1, 32'd2, 5'd0, 1'b0, 32'h0110, 1'b0));
    send(32'h002081FF, 32'h0200, 32'd1, 32'd2, 1'b0,
         mk("ill_opc", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h0200, 1'b1));
    send(32'h202081B3, 32'h0204, 32'd1, 32'd2, 1'b0,
         mk("ill_f7", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h0204, 1'b1));
    send(32'h0020A063, 32'h0208, 32'd1, 32'd2, 1'b0,
         mk("ill_br", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h0208, 1'b1));
    send(32'h40409293, 32'h020C, 32'd1, 32'd2, 1'b0,
         mk("ill_slli", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h020C, 1'b1));
    idle();
    idle();

    // Backpressure: A held for three cycles while B waits, then both move on one edge.
    ea = mk("bp_a", 4'd0, 32'h10, 32'h20, 5'd3, 1'b1, 32'h0300, 1'b0);
    eb = mk("bp_b", 4'd4, 32'hF0F0, 32'h0FF0, 5'd9, 1'b1, 32'h0304, 1'b0);
    send(32'h002081B3, 32'h0300, 32'h10, 32'h20, 1'b0, ea);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.instr = 32'h0020C4B3; bus.pc = 32'h0304;
    bus.rs1_data = 32'hF0F0; bus.rs2_data = 32'h0FF0;
    repeat (3) begin
      @(negedge clk);
      check("bp.in_ready",  32'(bus.in_ready),  32'd0);
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.alu_a",     bus.alu_a,          ea.a);
      check("bp.out_pc",    bus.out_pc,         ea.pc);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    check("bp.release_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back(eb);
    idle();
    idle();

    // Flush on the same edge as an accept drops the instruction.
    send(32'h0020E063, 32'h0400, 32'd1, 32'd2, 1'b1,
         mk("bltu_flushed", 4'd9, 32'd1, 32'd2, 5'd0, 1'b0, 32'h0400, 1'b0));
    idle();
    @(negedge clk);
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush.in_ready",  32'(bus.in_ready),  32'd1);

    // Asynchronous reset while holding.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'h0500, 32'h33, 32'h44, 1'b0,
         mk("held_rst", 4'd0, 32'h33, 32'h44, 5'd3, 1'b1, 32'h0500, 1'b0));
    idle();
    @(negedge clk);
    check("hold.out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(bus.out_valid),   32'd0);
    check("arst.alu_a",     bus.alu_a,            32'd0);
    check("arst.alu_b",     bus.alu_b,            32'd0);
    check("arst.alu_op",    32'(bus.alu_op),      32'd0);
    check("arst.out_rd",    32'(bus.out_rd),      32'd0);
    check("arst.out_we",    32'(bus.out_we),      32'd0);
    check("arst.out_pc",    bus.out_pc,           32'd0);
    check("arst.illegal",   32'(bus.out_illegal), 32'd0);
    check("arst.in_ready",  32'(bus.in_ready),    32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    idle();
    @(negedge clk);
    check("no_replay.out_valid", 32'(bus.out_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
